// File: rtl/instr_seq.sv
// instr_seq: program sequencer between the program ROM and the ISA decoder.
// Fetches words from a synchronous ROM, resolves HALT and JMP locally and
// issues every other word to the decoder over a valid/ready handshake.
// Optional single-step mode is enabled with the INSTR_SEQ_STEP_EN macro.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | stopped, waiting for start
// S_FETCH  | ROM read strobe issued at pc
// S_WAIT   | ROM data returns, captured into ir
// S_DECODE | opcode in ir resolved (halt / jump / issue)
// S_ISSUE  | word offered to decoder until dec_ready
// S_PAUSE  | (step mode only) waiting for step after an accepted issue

module instr_seq #(
    parameter int ADDRESS_BITS = 5,
    parameter int INSTR_BITS   = 3,
    localparam int VALUE_BITS  = INSTR_BITS + ADDRESS_BITS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDRESS_BITS-1:0] start_addr,
    input  logic                    halt_req,
`ifdef INSTR_SEQ_STEP_EN
    input  logic                    step,
`endif
    output logic [ADDRESS_BITS-1:0] rom_addr,
    output logic                    rom_rd,
    input  logic [VALUE_BITS-1:0]   rom_data,
    output logic [VALUE_BITS-1:0]   dec_value,
    output logic                    dec_enable,
    input  logic                    dec_ready,
    output logic [ADDRESS_BITS-1:0] pc,
    output logic                    busy,
    output logic                    done
);

    localparam logic [INSTR_BITS-1:0] OP_HALT = '0;
    localparam logic [INSTR_BITS-1:0] OP_JMP  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_ISSUE
`ifdef INSTR_SEQ_STEP_EN
        , S_PAUSE
`endif
    } state_t;

    state_t                  state, state_next;
    logic [ADDRESS_BITS-1:0] pc_next;
    logic [VALUE_BITS-1:0]   ir, ir_next;
    logic [VALUE_BITS-1:0]   dec_value_next;
    logic                    done_next;
    logic [INSTR_BITS-1:0]   opcode;

    assign opcode = ir[VALUE_BITS-1:ADDRESS_BITS];

    // State register and registered datapath outputs.
    // rom_addr shadows pc so the ROM address is a flop output, not a mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pc        <= '0;
            rom_addr  <= '0;
            ir        <= '0;
            dec_value <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            rom_addr  <= pc_next;
            ir        <= ir_next;
            dec_value <= dec_value_next;
            done      <= done_next;
        end
    end

    // Next-state and next-value logic for the sequencer.
    always_comb begin
        state_next     = state;
        pc_next        = pc;
        ir_next        = ir;
        dec_value_next = dec_value;
        done_next      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    pc_next    = start_addr;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                ir_next    = rom_data;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                if (halt_req || (opcode == OP_HALT)) begin
                    done_next  = 1'b1;
                    state_next = S_IDLE;
                end else if (opcode == OP_JMP) begin
                    pc_next    = ir[ADDRESS_BITS-1:0];
                    state_next = S_FETCH;
                end else begin
                    // Loaded only here so control-flow words never reach the decoder bus.
                    dec_value_next = ir;
                    state_next     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (dec_ready) begin
                    pc_next = pc + ADDRESS_BITS'(1);
`ifdef INSTR_SEQ_STEP_EN
                    state_next = S_PAUSE;
`else
                    state_next = S_FETCH;
`endif
                end
            end
`ifdef INSTR_SEQ_STEP_EN
            S_PAUSE: begin
                if (halt_req) begin
                    done_next  = 1'b1;
                    state_next = S_IDLE;
                end else if (step) begin
                    state_next = S_FETCH;
                end
            end
`endif
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign rom_rd     = (state == S_FETCH);
    assign dec_enable = (state == S_ISSUE);
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_instr_seq.sv
// Testbench for instr_seq: a program-level reference model computes the
// expected fetch addresses, issued words and final pc for each program; a
// compare process checks the DUT against it every cycle, and each directed
// test adds literal expectations.
module tb_instr_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [4:0] start_addr;
    logic       halt_req;
    logic       step;
    logic [4:0] rom_addr;
    logic       rom_rd;
    logic [7:0] rom_data;
    logic [7:0] dec_value;
    logic       dec_enable;
    logic       dec_ready;
    logic [4:0] pc;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    instr_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .halt_req   (halt_req),
`ifdef INSTR_SEQ_STEP_EN
        .step       (step),
`endif
        .rom_addr   (rom_addr),
        .rom_rd     (rom_rd),
        .rom_data   (rom_data),
        .dec_value  (dec_value),
        .dec_enable (dec_enable),
        .dec_ready  (dec_ready),
        .pc         (pc),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous program ROM: data one cycle after the read strobe.
    logic [7:0] rom [0:31];
    always @(posedge clk) if (rom_rd) rom_data <= rom[rom_addr];

    // Step pulses every third cycle (only connected in step mode).
    always @(negedge clk) step = (cyc % 3 == 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h, no such event expected", name, act);
    endtask

    // Reference model: executes the program at instruction level.
    logic [7:0] exp_issue [$];
    logic [4:0] exp_fetch [$];
    logic [4:0] exp_pc;
    logic [7:0] got_issue [$];
    int         acc_cyc [$];
    int         first_en;
    int         done_cnt;
    logic       model_on = 1'b0;

    function automatic void build_model(input logic [4:0] sa, input int halt_after);
        logic [4:0] p;
        logic [7:0] w;
        int         n;
        bit         halted;
        p = sa;
        n = 0;
        halted = 0;
        exp_issue.delete();
        exp_fetch.delete();
        for (int k = 0; k < 64; k++) begin
`ifdef INSTR_SEQ_STEP_EN
            if (halted) break;
`endif
            exp_fetch.push_back(p);
            w = rom[p];
            if (halted || w[7:5] == 3'b000) break;
            if (w[7:5] == 3'b111) begin
                p = w[4:0];
            end else begin
                exp_issue.push_back(w);
                n++;
                p = p + 5'd1;
                if (n == halt_after) halted = 1;
            end
        end
        exp_pc = p;
    endfunction

    // Per-cycle compare against the model, just after the inputs settle.
    logic       prev_en, prev_rdy;
    logic [7:0] prev_val;
    always @(negedge clk) begin
        #1;
        if (!rst_n || !model_on) begin
            prev_en = 1'b0;
        end else begin
            if (rom_rd) begin
                if (exp_fetch.size() == 0) fail_now("fetch_extra", 32'(rom_addr));
                else check("fetch_addr", 32'(rom_addr), 32'(exp_fetch.pop_front()));
            end
            if (dec_enable) begin
                if (first_en < 0) first_en = cyc;
                if (prev_en && !prev_rdy) check("hold_value", 32'(dec_value), 32'(prev_val));
                if (exp_issue.size() == 0) fail_now("issue_extra", 32'(dec_value));
                else check("issue_value", 32'(dec_value), 32'(exp_issue[0]));
                if (dec_ready) begin
                    if (exp_issue.size() != 0) void'(exp_issue.pop_front());
                    got_issue.push_back(dec_value);
                    acc_cyc.push_back(cyc);
                end
            end else if (prev_en && !prev_rdy) begin
                fail_now("issue_withdrawn", 32'(prev_val));
            end
            if (done) begin
                check("done_pc", 32'(pc), 32'(exp_pc));
                check("done_pending", exp_issue.size(), 0);
                done_cnt++;
            end
            if (!busy) check("idle_strobes", {30'd0, rom_rd, dec_enable}, 0);
            prev_en  = dec_enable;
            prev_rdy = dec_ready;
            prev_val = dec_value;
        end
    end

    task automatic load_prog(input int id);
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        case (id)
            1: begin rom[0] = 8'h21; rom[1] = 8'h45; rom[2] = 8'h00; end
            2: begin rom[0] = 8'hE3; rom[3] = 8'h9F; rom[4] = 8'h00; end
            default: begin rom[31] = 8'h22; rom[0] = 8'h00; end
        endcase
    endtask

    // Runs one program; returns the cycle of the start edge and pc at done.
    task automatic run_prog(input logic [4:0] sa, input int halt_after, input int ready_low,
                            output int e_cyc, output logic [4:0] done_pc);
        bit got;
        int en_cnt;
        build_model(sa, halt_after);
        got_issue.delete();
        acc_cyc.delete();
        first_en = -1;
        done_cnt = 0;
        halt_req = 1'b0;
        dec_ready = (ready_low == 0);
        model_on = 1'b1;
        @(negedge clk);
        start = 1'b1;
        start_addr = sa;
        @(negedge clk);
        start = 1'b0;
        e_cyc = cyc;
        check("start_rom_rd", 32'(rom_rd), 1);
        got = 0;
        en_cnt = 0;
        done_pc = '0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                done_pc = pc;
            end else if (dec_enable) begin
                en_cnt++;
                if (halt_after >= 0) halt_req = 1'b1;
                if (ready_low > 0) begin
                    if (en_cnt <= ready_low) begin
                        check("bp_pc_held", 32'(pc), 32'(sa));
                        check("bp_value", 32'(dec_value), 32'h21);
                        dec_ready = 1'b0;
                    end else begin
                        dec_ready = 1'b1;
                    end
                end
            end
        end
        if (!got) fail_now("done_timeout", 32'(busy));
        @(negedge clk);
        check("done_single", 32'(done), 0);
        check("busy_after", 32'(busy), 0);
        halt_req = 1'b0;
        model_on = 1'b0;
    endtask

    int         e;
    logic [4:0] dpc;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        start_addr = '0;
        halt_req = 1'b0;
        dec_ready = 1'b1;
        rom_data = '0;
        load_prog(1);
        #1;
        check("rst_rom_addr", 32'(rom_addr), 0);
        check("rst_rom_rd", 32'(rom_rd), 0);
        check("rst_dec_value", 32'(dec_value), 0);
        check("rst_dec_enable", 32'(dec_enable), 0);
        check("rst_pc", 32'(pc), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Sequential issue.
        load_prog(1);
        run_prog(5'd0, -1, 0, e, dpc);
        check("t1_model_pc", 32'(exp_pc), 2);
        check("t1_pc", 32'(dpc), 2);
        check("t1_done_count", done_cnt, 1);
        check("t1_issue_count", got_issue.size(), 2);
        if (got_issue.size() == 2) begin
            check("t1_issue0", 32'(got_issue[0]), 32'h21);
            check("t1_issue1", 32'(got_issue[1]), 32'h45);
        end
        check("t1_latency", first_en - e, 3);
`ifndef INSTR_SEQ_STEP_EN
        if (acc_cyc.size() == 2) check("t1_rate", acc_cyc[1] - acc_cyc[0], 4);
`endif

        // Jump.
        load_prog(2);
        run_prog(5'd0, -1, 0, e, dpc);
        check("t2_model_pc", 32'(exp_pc), 4);
        check("t2_pc", 32'(dpc), 4);
        check("t2_issue_count", got_issue.size(), 1);
        if (got_issue.size() == 1) check("t2_issue0", 32'(got_issue[0]), 32'h9F);

        // Back-pressure on the first issue.
        load_prog(1);
        run_prog(5'd0, -1, 5, e, dpc);
        check("t3_pc", 32'(dpc), 2);
        check("t3_issue_count", got_issue.size(), 2);
        if (got_issue.size() == 2) check("t3_issue0", 32'(got_issue[0]), 32'h21);

        // Wrap-around.
        load_prog(3);
        run_prog(5'd31, -1, 0, e, dpc);
        check("t4_model_pc", 32'(exp_pc), 0);
        check("t4_pc", 32'(dpc), 0);
        check("t4_issue_count", got_issue.size(), 1);
        if (got_issue.size() == 1) check("t4_issue0", 32'(got_issue[0]), 32'h22);

        // halt_req raised during the first issue.
        load_prog(1);
        run_prog(5'd0, 1, 0, e, dpc);
        check("t5_model_pc", 32'(exp_pc), 1);
        check("t5_pc", 32'(dpc), 1);
        check("t5_issue_count", got_issue.size(), 1);
        if (got_issue.size() == 1) check("t5_issue0", 32'(got_issue[0]), 32'h21);

        // Reset pulsed mid-issue, then a clean rerun.
        load_prog(1);
        dec_ready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        start_addr = 5'd0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20 && !dec_enable; k++) @(negedge clk);
        check("t6_in_issue", 32'(dec_enable), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_dec_enable", 32'(dec_enable), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_pc", 32'(pc), 0);
        check("t6_rst_dec_value", 32'(dec_value), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dec_ready = 1'b1;
        run_prog(5'd0, -1, 0, e, dpc);
        check("t6_pc", 32'(dpc), 2);
        check("t6_issue_count", got_issue.size(), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
